// File: rtl/nbr128_ctrl.sv
// Evaluation controller for a 128-bit challenge ring PUF: resets and settles the ring
// N times, samples its synchronized output each time and majority-votes the result.
module nbr128_ctrl #(
    parameter int RESET_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         REQ_VALID,
    output logic         REQ_READY,
    input  logic [127:0] REQ_CHAL,
    input  logic [3:0]   REQ_NEVAL,
    output logic         PUF_RESET,
    output logic [127:0] PUF_C,
    input  logic         PUF_OUT,
    output logic         RSP_VALID,
    input  logic         RSP_READY,
    output logic         RSP_BIT,
    output logic [3:0]   RSP_ONES,
    output logic         RSP_STABLE
);
    localparam logic [15:0] RST_LAST    = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [15:0]    r_cnt;
    logic [3:0]     r_n;
    logic [3:0]     r_eval;
    logic [3:0]     r_ones;
    logic           r_sync1;
    logic           r_sync2;
    logic [127:0]   r_puf_c;
    logic           r_rsp_valid;
    logic           r_rsp_bit;
    logic [3:0]     r_rsp_ones;
    logic           r_rsp_stable;
    logic           w_accept;
    logic [3:0]     w_eval_inc;
    logic [3:0]     w_ones_inc;
    logic [4:0]     w_twice_ones;

    assign w_eval_inc   = r_eval + 4'd1;
    assign w_ones_inc   = r_ones + {3'b000, r_sync2};
    assign w_twice_ones = {r_ones, 1'b0};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        REQ_READY    = 1'b0;
        PUF_RESET    = 1'b1;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RST;
                end
            end
            S_RST: begin
                if (r_cnt == RST_LAST) w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                PUF_RESET = 1'b0;
                if (r_cnt == SETTLE_LAST) w_state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                PUF_RESET    = 1'b0;
                w_state_next = (w_eval_inc == r_n) ? S_DONE : S_RST;
            end
            S_DONE: begin
                // Response registers load on the first DONE cycle; handshake only once valid.
                if (r_rsp_valid && RSP_READY) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_cnt        <= '0;
            r_n          <= '0;
            r_eval       <= '0;
            r_ones       <= '0;
            r_puf_c      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_bit    <= 1'b0;
            r_rsp_ones   <= '0;
            r_rsp_stable <= 1'b0;
        end else begin
            r_sync1 <= PUF_OUT;
            r_sync2 <= r_sync1;

            // Phase counter restarts whenever the state changes.
            if ((r_state == S_RST || r_state == S_SETTLE) && (w_state_next == r_state)) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= '0;
            end

            if (w_accept) begin
                r_puf_c <= REQ_CHAL;
                r_n     <= (REQ_NEVAL == 4'd0) ? 4'd1 : REQ_NEVAL;
                r_ones  <= '0;
                r_eval  <= '0;
            end

            if (r_state == S_SAMPLE) begin
                r_ones <= w_ones_inc;
                r_eval <= w_eval_inc;
            end

            if (r_state == S_DONE) begin
                if (!r_rsp_valid) begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_bit    <= (w_twice_ones > {1'b0, r_n});
                    r_rsp_ones   <= r_ones;
                    r_rsp_stable <= (r_ones == 4'd0) || (r_ones == r_n);
                end else if (RSP_READY) begin
                    r_rsp_valid <= 1'b0;
                end
            end
        end
    end

    assign PUF_C      = r_puf_c;
    assign RSP_VALID  = r_rsp_valid;
    assign RSP_BIT    = r_rsp_bit;
    assign RSP_ONES   = r_rsp_ones;
    assign RSP_STABLE = r_rsp_stable;
endmodule

// File: tb/tb_nbr128_ctrl.sv
// Directed bench for nbr128_ctrl: voting, latency, reset-pulse shape, hold and abort.
module tb_nbr128_ctrl;
    logic         CLK = 1'b0;
    logic         RESET;
    logic         REQ_VALID;
    logic         REQ_READY;
    logic [127:0] REQ_CHAL;
    logic [3:0]   REQ_NEVAL;
    logic         PUF_RESET;
    logic [127:0] PUF_C;
    logic         PUF_OUT;
    logic         RSP_VALID;
    logic         RSP_READY;
    logic         RSP_BIT;
    logic [3:0]   RSP_ONES;
    logic         RSP_STABLE;

    int checks = 0;
    int errors = 0;

    nbr128_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_CHAL(REQ_CHAL), .REQ_NEVAL(REQ_NEVAL),
        .PUF_RESET(PUF_RESET), .PUF_C(PUF_C), .PUF_OUT(PUF_OUT),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_BIT(RSP_BIT), .RSP_ONES(RSP_ONES), .RSP_STABLE(RSP_STABLE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it until RSP_VALID; PUF_OUT for evaluation i is pat[i],
    // applied when that evaluation's ring reset is released.
    task automatic run_req(input logic [127:0] chal, input logic [3:0] neval, input logic [15:0] pat,
                           output int lat, output int pulses, output int bad_runs,
                           output int c_bad, output int busy_ready);
        int w;
        int run;
        logic prev;
        REQ_CHAL  = chal;
        REQ_NEVAL = neval;
        REQ_VALID = 1'b1;
        w = 0;
        while (REQ_READY !== 1'b1 && w < 100) begin
            @(posedge CLK); #1; w++;
        end
        @(posedge CLK); #1;
        REQ_VALID  = 1'b0;
        REQ_CHAL   = ~chal;
        REQ_NEVAL  = 4'd9;
        lat        = 0;
        pulses     = 0;
        bad_runs   = 0;
        c_bad      = 0;
        busy_ready = 0;
        run        = PUF_RESET ? 1 : 0;
        prev       = PUF_RESET;
        while (RSP_VALID !== 1'b1 && lat < 3000) begin
            @(posedge CLK); #1;
            lat++;
            if (PUF_C !== chal) c_bad++;
            if (REQ_READY !== 1'b0) busy_ready++;
            if (PUF_RESET) begin
                run++;
            end else if (prev) begin
                pulses++;
                if (run != 8) bad_runs++;
                run = 0;
                if (pulses <= 16) PUF_OUT = pat[pulses-1];
            end
            prev = PUF_RESET;
        end
    endtask

    // Verify response fields, hold for 'hold' cycles without RSP_READY, then hand it off.
    task automatic finish_rsp(input string name, input int hold, input logic exp_bit,
                              input logic [3:0] exp_ones, input logic exp_stable);
        int changes;
        int rdy_seen;
        check({name, " RSP_BIT"}, 128'(RSP_BIT), 128'(exp_bit));
        check({name, " RSP_ONES"}, 128'(RSP_ONES), 128'(exp_ones));
        check({name, " RSP_STABLE"}, 128'(RSP_STABLE), 128'(exp_stable));
        changes  = 0;
        rdy_seen = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            if (RSP_VALID !== 1'b1 || RSP_BIT !== exp_bit || RSP_ONES !== exp_ones ||
                RSP_STABLE !== exp_stable) changes++;
            if (REQ_READY !== 1'b0) rdy_seen++;
        end
        if (hold > 0) begin
            check({name, " hold changes"}, 128'(changes), 128'(0));
            check({name, " hold REQ_READY"}, 128'(rdy_seen), 128'(0));
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        check({name, " post RSP_VALID"}, 128'(RSP_VALID), 128'(0));
        check({name, " post REQ_READY"}, 128'(REQ_READY), 128'(1));
        $display("txn %s ones=%0d bit=%0d stable=%0d", name, RSP_ONES, RSP_BIT, RSP_STABLE);
    endtask

    task automatic txn(input string name, input logic [127:0] chal, input logic [3:0] neval,
                       input logic [15:0] pat, input int exp_n, input logic exp_bit,
                       input logic [3:0] exp_ones, input logic exp_stable, input int hold);
        int lat, pulses, bad_runs, c_bad, busy_ready;
        run_req(chal, neval, pat, lat, pulses, bad_runs, c_bad, busy_ready);
        check({name, " latency"}, 128'(lat), 128'(exp_n * 73 + 1));
        check({name, " reset pulses"}, 128'(pulses), 128'(exp_n));
        check({name, " pulse width"}, 128'(bad_runs), 128'(0));
        check({name, " PUF_C"}, PUF_C, chal);
        check({name, " PUF_C held"}, 128'(c_bad), 128'(0));
        check({name, " busy REQ_READY"}, 128'(busy_ready), 128'(0));
        finish_rsp(name, hold, exp_bit, exp_ones, exp_stable);
    endtask

    initial begin
        logic [127:0] chal_a5;
        logic [127:0] chal_e;
        int w;
        int pulses;
        int valid_seen;
        logic prev;
        chal_a5   = {16{8'hA5}};
        chal_e    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        RESET     = 1'b1;
        REQ_VALID = 1'b0;
        REQ_CHAL  = '1;
        REQ_NEVAL = 4'd3;
        PUF_OUT   = 1'b1;
        RSP_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst PUF_C", PUF_C, 128'(0));
        check("rst PUF_RESET", 128'(PUF_RESET), 128'(1));
        check("rst RSP_VALID", 128'(RSP_VALID), 128'(0));
        check("rst RSP_BIT", 128'(RSP_BIT), 128'(0));
        check("rst RSP_ONES", 128'(RSP_ONES), 128'(0));
        check("rst RSP_STABLE", 128'(RSP_STABLE), 128'(0));
        check("rst REQ_READY", 128'(REQ_READY), 128'(1));
        RESET     = 1'b0;
        RSP_READY = 1'b0;
        PUF_OUT   = 1'b0;
        @(posedge CLK); #1;

        txn("n1_a5",    chal_a5, 4'd1, 16'h0001, 1, 1'b1, 4'd1, 1'b1, 20);
        txn("n5_vote",  128'h5,  4'd5, 16'h000B, 5, 1'b1, 4'd3, 1'b0, 0);
        txn("n4_tie",   128'hC3, 4'd4, 16'h0005, 4, 1'b0, 4'd2, 1'b0, 0);
        txn("n0_as_1",  128'h77, 4'd0, 16'h0000, 1, 1'b0, 4'd0, 1'b1, 0);

        // Abort: reset during SETTLE of the second of three evaluations.
        REQ_CHAL  = chal_e;
        REQ_NEVAL = 4'd3;
        REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        pulses = 0;
        prev   = PUF_RESET;
        w      = 0;
        while (pulses < 2 && w < 1000) begin
            @(posedge CLK); #1;
            w++;
            if (!PUF_RESET && prev) pulses++;
            prev = PUF_RESET;
        end
        check("abort reached 2nd settle", 128'(pulses), 128'(2));
        repeat (10) @(posedge CLK);
        #1;
        check("abort PUF_RESET in settle", 128'(PUF_RESET), 128'(0));
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        check("abort PUF_C", PUF_C, 128'(0));
        check("abort PUF_RESET", 128'(PUF_RESET), 128'(1));
        check("abort RSP_VALID", 128'(RSP_VALID), 128'(0));
        check("abort RSP_BIT", 128'(RSP_BIT), 128'(0));
        check("abort RSP_ONES", 128'(RSP_ONES), 128'(0));
        check("abort RSP_STABLE", 128'(RSP_STABLE), 128'(0));
        check("abort REQ_READY", 128'(REQ_READY), 128'(1));
        valid_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge CLK); #1;
            if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1) valid_seen++;
        end
        check("abort no response", 128'(valid_seen), 128'(0));
        $display("txn abort pulses_before_reset=%0d", pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
